// File: rtl/l1_device_responder_pkg.sv
// Shared bus definitions for the L1 device-side responder and its FIFOs.
package l1_device_responder_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDR_DEV_WIDTH = 20;

    typedef enum logic [1:0] {
        DEV_GPIO    = 2'd0,
        DEV_UART    = 2'd1,
        DEV_TIMER   = 2'd2,
        DEV_SIMCTRL = 2'd3
    } bus_device_e;

    typedef enum logic {
        HOST_CORE   = 1'b0,
        HOST_FRAISE = 1'b1
    } bus_host_e;

    // A one-entry FIFO still needs a one-bit pointer.
    function automatic int unsigned ptr_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/l1_device_responder_if.sv
// Interconnect request/response port plus the single-cycle peripheral port.
interface l1_device_responder_if
    import l1_device_responder_pkg::*;
#(
    parameter int unsigned DataWidth    = DATA_WIDTH,
    parameter int unsigned AddrWidth    = ADDR_DEV_WIDTH,
    parameter int unsigned DevAddrWidth = 32,
    parameter int unsigned NbrHostsLog2 = 1
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [NbrHostsLog2-1:0] req_ini_addr_i;
    logic [AddrWidth-1:0]    req_tgt_addr_i;
    logic                    req_wen_i;
    logic [DataWidth-1:0]    req_wdata_i;
    logic [DataWidth/8-1:0]  req_be_i;

    logic                    resp_valid_o;
    logic                    resp_ready_i;
    logic [NbrHostsLog2-1:0] resp_ini_addr_o;
    logic [DataWidth-1:0]    resp_rdata_o;

    logic                    device_req_o;
    logic [DevAddrWidth-1:0] device_addr_o;
    logic                    device_we_o;
    logic [DataWidth/8-1:0]  device_be_o;
    logic [DataWidth-1:0]    device_wdata_o;
    logic                    device_rvalid_i;
    logic [DataWidth-1:0]    device_rdata_i;

    logic                    protocol_err_o;

    // Interconnect plus peripheral stimulus side.
    modport master (
        output req_valid_i, req_ini_addr_i, req_tgt_addr_i, req_wen_i, req_wdata_i, req_be_i,
        output resp_ready_i, device_rvalid_i, device_rdata_i,
        input  req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o,
        input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        input  protocol_err_o
    );

    // Responder side.
    modport slave (
        input  req_valid_i, req_ini_addr_i, req_tgt_addr_i, req_wen_i, req_wdata_i, req_be_i,
        input  resp_ready_i, device_rvalid_i, device_rdata_i,
        output req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o,
        output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        output protocol_err_o
    );

endinterface

// File: rtl/l1_device_responder_sync_fifo.sv
// Registered-output synchronous FIFO; a push into an empty FIFO shows up next cycle.
module l1_device_responder_sync_fifo
    import l1_device_responder_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int unsigned PtrW = ptr_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count == '0);
    assign full_o  = (count == CntW'(Depth));
    assign head_o  = mem[rd_ptr];
    // Popping an empty FIFO is ignored, so a same-cycle push into it wins.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage array: written on push only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l1_device_responder.sv
// L1 device responder: forwards accepted requests to a single-cycle peripheral
// and returns one in-order response per request with the originating host index.
module l1_device_responder
    import l1_device_responder_pkg::*;
#(
    parameter int unsigned DataWidth    = DATA_WIDTH,
    parameter int unsigned AddrWidth    = ADDR_DEV_WIDTH,
    parameter int unsigned DevAddrWidth = 32,
    parameter int unsigned NbrHostsLog2 = 1,
    parameter int unsigned Depth        = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    l1_device_responder_if.slave   bus
);
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned TagW  = NbrHostsLog2 + 1;
    localparam int unsigned RespW = NbrHostsLog2 + DataWidth;

    logic [CntW-1:0]         outstanding;
    logic                    accept;
    logic                    resp_hs;
    logic                    err_q;

    logic [TagW-1:0]         tag_head;
    logic                    tag_empty;
    logic                    unused_tag_full;
    logic [NbrHostsLog2-1:0] tag_ini;
    logic                    tag_we;

    logic                    resp_push;
    logic [DataWidth-1:0]    resp_rdata_in;
    logic [RespW-1:0]        resp_head;
    logic                    resp_empty;
    logic                    unused_resp_full;

    // Ready depends only on the credit counter, never on req_valid.
    assign bus.req_ready_o    = (outstanding < CntW'(Depth));
    assign accept             = bus.req_valid_i & bus.req_ready_o;
    assign resp_hs            = bus.resp_valid_o & bus.resp_ready_i;

    assign bus.device_req_o   = accept;
    assign bus.device_addr_o  = DevAddrWidth'(bus.req_tgt_addr_i);
    assign bus.device_we_o    = bus.req_wen_i;
    assign bus.device_be_o    = bus.req_be_i;
    assign bus.device_wdata_o = bus.req_wdata_i;

    assign tag_ini       = tag_head[TagW-1:1];
    assign tag_we        = tag_head[0];
    assign resp_push     = bus.device_rvalid_i & ~tag_empty;
    assign resp_rdata_in = tag_we ? '0 : bus.device_rdata_i;

    assign bus.resp_valid_o    = ~resp_empty;
    assign bus.resp_ini_addr_o = resp_head[RespW-1:DataWidth];
    assign bus.resp_rdata_o    = resp_head[DataWidth-1:0];
    assign bus.protocol_err_o  = err_q;

    l1_device_responder_sync_fifo #(.Width(TagW), .Depth(Depth)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  ({bus.req_ini_addr_i, bus.req_wen_i}),
        .pop_i   (bus.device_rvalid_i),
        .full_o  (unused_tag_full),
        .empty_o (tag_empty),
        .head_o  (tag_head)
    );

    l1_device_responder_sync_fifo #(.Width(RespW), .Depth(Depth)) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (resp_push),
        .data_i  ({tag_ini, resp_rdata_in}),
        .pop_i   (resp_hs),
        .full_o  (unused_resp_full),
        .empty_o (resp_empty),
        .head_o  (resp_head)
    );

    // Credit counter: one credit per request from accept until its response handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else begin
            case ({accept, resp_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky flag for a peripheral response that matches no pending request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (bus.device_rvalid_i && tag_empty) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_l1_device_responder.sv
// Scoreboard bench for l1_device_responder: stimulus pushes expected responses,
// a monitor checks ready/credit, passthroughs, latency, ordering, stall stability and the error flag.
module tb_l1_device_responder;
    import l1_device_responder_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 20;
    localparam int DAW   = 32;
    localparam int HW    = 1;
    localparam int DEPTH = 2;

    typedef struct {
        logic [HW-1:0] ini;
        logic [DW-1:0] data;
        int            acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    l1_device_responder_if #(.DataWidth(DW), .AddrWidth(AW), .DevAddrWidth(DAW), .NbrHostsLog2(HW)) bus ();

    l1_device_responder #(
        .DataWidth(DW), .AddrWidth(AW), .DevAddrWidth(DAW), .NbrHostsLog2(HW), .Depth(DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    exp_t          exp_q[$];
    int            compared   = 0;
    int            mismatched = 0;
    int            cyc        = 0;
    logic          next_rv    = 1'b0;
    logic [DW-1:0] next_rdata = '0;
    logic          rv_legit   = 1'b0;
    logic          exp_err    = 1'b0;
    int            model_out  = 0;
    logic          held_v     = 1'b0;
    logic [HW-1:0] held_ini   = '0;
    logic [DW-1:0] held_data  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: inputs change on the falling edge; the peripheral model
    // answers every accepted request one cycle later with rdata_pick.
    task automatic drive(input logic v, input logic [HW-1:0] ini, input logic [AW-1:0] a,
                         input logic we, input logic [DW-1:0] wd, input logic [3:0] be,
                         input logic rr, input logic [DW-1:0] rdata_pick, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.device_rvalid_i = next_rv;
        bus.device_rdata_i  = next_rv ? next_rdata : DW'($urandom);
        rv_legit            = next_rv;
        bus.req_valid_i     = v;
        bus.req_ini_addr_i  = ini;
        bus.req_tgt_addr_i  = a;
        bus.req_wen_i       = we;
        bus.req_wdata_i     = wd;
        bus.req_be_i        = be;
        bus.resp_ready_i    = rr;
        #2;
        acc = v && bus.req_ready_o;
        if (acc) begin
            next_rv    = 1'b1;
            next_rdata = rdata_pick;
            e.ini      = ini;
            e.data     = we ? '0 : rdata_pick;
            e.acc_cyc  = cyc;
            exp_q.push_back(e);
        end else begin
            next_rv = 1'b0;
        end
    endtask

    task automatic idle(input logic rr);
        logic acc;
        drive(1'b0, '0, '0, 1'b0, '0, '0, rr, '0, acc);
    endtask

    task automatic rd(input logic [HW-1:0] ini, input logic [AW-1:0] a, input logic [DW-1:0] rdata,
                      input logic rr);
        logic acc;
        drive(1'b1, ini, a, 1'b0, DW'($urandom), 4'hF, rr, rdata, acc);
    endtask

    // Holds a request until it is accepted, with a cycle budget.
    task automatic send_req(input logic [HW-1:0] ini, input logic [AW-1:0] a, input logic we,
                            input logic [DW-1:0] wd, input logic [3:0] be, input logic [DW-1:0] rdata);
        logic acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            drive(1'b1, ini, a, we, wd, be, 1'b1, rdata, acc);
        end
        check("send_accept", acc, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        check("drain_empty", exp_q.size() == 0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni              = 1'b0;
        exp_q.delete();
        next_rv             = 1'b0;
        rv_legit            = 1'b0;
        bus.device_rvalid_i = 1'b0;
        bus.req_valid_i     = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic spurious_rvalid();
        @(negedge clk);
        bus.device_rvalid_i = 1'b1;
        bus.device_rdata_i  = DW'($urandom);
        rv_legit            = 1'b0;
        bus.req_valid_i     = 1'b0;
        bus.resp_ready_i    = 1'b1;
        next_rv             = 1'b0;
    endtask

    // Monitor: samples late in the low phase, after the stimulus has settled.
    always @(negedge clk) begin
        logic exp_ready;
        logic acc;
        logic popped;
        exp_t head;
        #3;
        if (!rst_ni) begin
            check("rst_resp_valid", bus.resp_valid_o, 1'b0);
            check("rst_req_ready", bus.req_ready_o, 1'b1);
            check("rst_protocol_err", bus.protocol_err_o, 1'b0);
            model_out = 0;
            held_v    = 1'b0;
            exp_err   = 1'b0;
        end else begin
            exp_ready = (model_out < DEPTH);
            check("req_ready", bus.req_ready_o, exp_ready);
            acc = bus.req_valid_i && exp_ready;
            check("device_req", bus.device_req_o, acc);
            if (acc) begin
                check("device_addr", bus.device_addr_o, {{(DAW-AW){1'b0}}, bus.req_tgt_addr_i});
                check("device_we", bus.device_we_o, bus.req_wen_i);
                check("device_be", bus.device_be_o, bus.req_be_i);
                check("device_wdata", bus.device_wdata_o, bus.req_wdata_i);
            end
            check("protocol_err", bus.protocol_err_o, exp_err);
            if (bus.device_rvalid_i && !rv_legit) exp_err = 1'b1;
            if (held_v) begin
                check("hold_valid", bus.resp_valid_o, 1'b1);
                check("hold_ini", bus.resp_ini_addr_o, held_ini);
                check("hold_rdata", bus.resp_rdata_o, held_data);
            end
            popped = 1'b0;
            if (exp_q.size() == 0) begin
                check("resp_valid_idle", bus.resp_valid_o, 1'b0);
            end else begin
                head = exp_q[0];
                if (cyc >= head.acc_cyc + 2) check("resp_valid_due", bus.resp_valid_o, 1'b1);
                else                         check("resp_valid_early", bus.resp_valid_o, 1'b0);
                if (bus.resp_valid_o && bus.resp_ready_i) begin
                    check("resp_ini", bus.resp_ini_addr_o, head.ini);
                    check("resp_rdata", bus.resp_rdata_o, head.data);
                    void'(exp_q.pop_front());
                    popped = 1'b1;
                end
            end
            model_out = model_out + (acc ? 1 : 0) - (popped ? 1 : 0);
            held_v    = bus.resp_valid_o && !bus.resp_ready_i;
            held_ini  = bus.resp_ini_addr_o;
            held_data = bus.resp_rdata_o;
        end
    end

    initial begin
        logic acc;
        bus.req_valid_i     = 1'b0;
        bus.req_ini_addr_i  = '0;
        bus.req_tgt_addr_i  = '0;
        bus.req_wen_i       = 1'b0;
        bus.req_wdata_i     = '0;
        bus.req_be_i        = '0;
        bus.resp_ready_i    = 1'b0;
        bus.device_rvalid_i = 1'b0;
        bus.device_rdata_i  = '0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // Single read and single write.
        rd(1'b1, 20'h00004, 32'hDEADBEEF, 1'b1);
        repeat (3) idle(1'b1);
        drive(1'b1, 1'b0, 20'h00010, 1'b1, 32'h12345678, 4'b0011, 1'b1, 32'hCAFEF00D, acc);
        repeat (3) idle(1'b1);

        // Credit exhaustion under backpressure, third read held until a credit frees.
        rd(1'b0, 20'h00020, 32'h11111111, 1'b0);
        rd(1'b1, 20'h00024, 32'h22222222, 1'b0);
        repeat (3) rd(1'b0, 20'h00028, 32'h33333333, 1'b0);
        send_req(1'b0, 20'h00028, 1'b0, '0, 4'hF, 32'h33333333);
        drain();

        // Alternating backpressure with interleaved hosts.
        rd(1'b0, 20'h00100, 32'hAAAA0000, 1'b1);
        rd(1'b1, 20'h00104, 32'hBBBB1111, 1'b0);
        send_req(1'b0, 20'h00108, 1'b0, '0, 4'hF, 32'hCCCC2222);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, HW'($urandom), AW'($urandom), 1'($urandom),
                  DW'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, DW'($urandom), acc);
        end
        drain();

        // Reset with two requests in flight: nothing stale may come out.
        rd(1'b1, 20'h00200, 32'h55555555, 1'b0);
        rd(1'b0, 20'h00204, 32'h66666666, 1'b0);
        do_reset();
        repeat (6) idle(1'b1);

        // Peripheral response with nothing pending.
        spurious_rvalid();
        repeat (4) idle(1'b1);
        send_req(1'b1, 20'h00300, 1'b0, '0, 4'hF, 32'h0BADCAFE);
        drain();

        // Reset clears the sticky error.
        do_reset();
        repeat (3) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
